// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge SDRAM sequencer/arbiter.
package cart_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Grant encoding for the requester currently owning the SDRAM port
    typedef enum logic [1:0] {
        GNT_LD = 2'd0,
        GNT_A  = 2'd1,
        GNT_B  = 2'd2
    } gnt_e;

    // Encoding of the round-robin 'last served slot' bit
    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

    // Data returned by a read that the watchdog had to abort
    localparam logic [7:0] RD_ABORT = 8'hFF;

endpackage

// File: rtl/cart_rd_cache.sv
// One-entry read cache for a cartridge slot: address/data/valid with a hit
// compare, a fill port and a clear that invalidates the entry.
module cart_rd_cache
    import cart_pkg::*;
#(
    parameter int AW = 25
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] lookup_addr,
    output logic          hit,
    output logic [7:0]    data,
    input  logic          fill,
    input  logic [AW-1:0] fill_addr,
    input  logic [7:0]    fill_data,
    input  logic          clear
);

    logic          valid_r;
    logic [AW-1:0] addr_r;
    logic [7:0]    data_r;

    // Entry update: clear wins over fill so a ROM change never leaves a stale line
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            addr_r  <= '0;
            data_r  <= RD_ABORT;
        end else if (clear) begin
            valid_r <= 1'b0;
        end else if (fill) begin
            valid_r <= 1'b1;
            addr_r  <= fill_addr;
            data_r  <= fill_data;
        end
    end

    assign hit  = valid_r && (addr_r == lookup_addr);
    assign data = data_r;

endmodule

// File: rtl/cart_sdram_arb.sv
// Sequencer and arbiter sharing the byte-wide SDRAM command port between the
// ROM loader (writes) and the read ports of cartridge slots A and B, with a
// one-entry read cache per slot and a watchdog against a stuck controller.
module cart_sdram_arb
    import cart_pkg::*;
#(
    parameter int AW      = 25,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          ld_ack,
    output logic          ld_wait,
    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    output logic          a_ack,
    output logic [7:0]    a_dout,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    output logic          b_ack,
    output logic [7:0]    b_dout,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_we,
    output logic          mem_rd,
    input  logic [7:0]    mem_dout,
    input  logic          mem_ready,
    output logic          err
);

    localparam int             WDW      = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WDOG_MAX = WDW'(TIMEOUT);

    state_e         state_r;
    gnt_e           gnt_r;
    logic           last_r;
    logic [WDW-1:0] wdog_r;
    logic [7:0]     rd_data_r;
    logic           aborted_r;

    logic           ld_live_s;
    logic           a_live_s;
    logic           b_live_s;
    logic           a_win_s;
    logic           b_win_s;
    logic           a_hit_s;
    logic           b_hit_s;
    logic [7:0]     a_cache_data_s;
    logic [7:0]     b_cache_data_s;
    logic           a_fill_s;
    logic           b_fill_s;
    logic           cache_clr_s;

    // A request is ignored during its own ack cycle; if still high after that
    // it is a new request.
    assign ld_live_s = ld_req & ~ld_ack;
    assign a_live_s  = a_req  & ~a_ack;
    assign b_live_s  = b_req  & ~b_ack;

    // Round robin between the slots: the one not served last wins a tie
    assign a_win_s = a_live_s & (~b_live_s | (last_r == LAST_B));
    assign b_win_s = b_live_s & ~a_win_s;

    assign ld_wait = ld_req & ~ld_ack;

    // Cache maintenance happens in DONE; mem_addr still holds the request address
    assign a_fill_s    = (state_r == DONE) && (gnt_r == GNT_A) && !aborted_r;
    assign b_fill_s    = (state_r == DONE) && (gnt_r == GNT_B) && !aborted_r;
    assign cache_clr_s = (state_r == DONE) && (gnt_r == GNT_LD);

    cart_rd_cache #(.AW(AW)) u_cache_a (
        .clk         (clk),
        .reset       (reset),
        .lookup_addr (a_addr),
        .hit         (a_hit_s),
        .data        (a_cache_data_s),
        .fill        (a_fill_s),
        .fill_addr   (mem_addr),
        .fill_data   (rd_data_r),
        .clear       (cache_clr_s)
    );

    cart_rd_cache #(.AW(AW)) u_cache_b (
        .clk         (clk),
        .reset       (reset),
        .lookup_addr (b_addr),
        .hit         (b_hit_s),
        .data        (b_cache_data_s),
        .fill        (b_fill_s),
        .fill_addr   (mem_addr),
        .fill_data   (rd_data_r),
        .clear       (cache_clr_s)
    );

    // Arbitration FSM, command issue, watchdog and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            gnt_r     <= GNT_LD;
            last_r    <= LAST_B;
            wdog_r    <= '0;
            rd_data_r <= RD_ABORT;
            aborted_r <= 1'b0;
            ld_ack    <= 1'b0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_dout    <= RD_ABORT;
            b_dout    <= RD_ABORT;
            mem_addr  <= '0;
            mem_din   <= 8'h00;
            mem_we    <= 1'b0;
            mem_rd    <= 1'b0;
            err       <= 1'b0;
        end else begin
            ld_ack <= 1'b0;
            a_ack  <= 1'b0;
            b_ack  <= 1'b0;
            mem_we <= 1'b0;
            mem_rd <= 1'b0;
            case (state_r)
                IDLE: begin
                    wdog_r    <= '0;
                    aborted_r <= 1'b0;
                    if (ld_live_s) begin
                        if (mem_ready) begin
                            gnt_r    <= GNT_LD;
                            mem_addr <= ld_addr;
                            mem_din  <= ld_data;
                            mem_we   <= 1'b1;
                            state_r  <= ISSUE;
                        end
                    end else if (a_win_s) begin
                        if (a_hit_s) begin
                            a_ack  <= 1'b1;
                            a_dout <= a_cache_data_s;
                        end else if (mem_ready) begin
                            gnt_r    <= GNT_A;
                            mem_addr <= a_addr;
                            mem_rd   <= 1'b1;
                            state_r  <= ISSUE;
                        end
                    end else if (b_win_s) begin
                        if (b_hit_s) begin
                            b_ack  <= 1'b1;
                            b_dout <= b_cache_data_s;
                        end else if (mem_ready) begin
                            gnt_r    <= GNT_B;
                            mem_addr <= b_addr;
                            mem_rd   <= 1'b1;
                            state_r  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // mem_ready here may still reflect the previous command
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (mem_ready) begin
                        rd_data_r <= mem_dout;
                        state_r   <= DONE;
                    end else if (wdog_r == WDOG_MAX) begin
                        err       <= 1'b1;
                        aborted_r <= 1'b1;
                        rd_data_r <= RD_ABORT;
                        state_r   <= DONE;
                    end else begin
                        wdog_r <= wdog_r + 1'b1;
                    end
                end
                DONE: begin
                    case (gnt_r)
                        GNT_LD: ld_ack <= 1'b1;
                        GNT_A: begin
                            a_ack  <= 1'b1;
                            a_dout <= rd_data_r;
                            last_r <= LAST_A;
                        end
                        GNT_B: begin
                            b_ack  <= 1'b1;
                            b_dout <= rd_data_r;
                            last_r <= LAST_B;
                        end
                        default: last_r <= last_r;
                    endcase
                    state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cart_sdram_arb.sv
// Directed self-checking bench for cart_sdram_arb. The SDRAM model returns
// mem_addr[7:0] ^ mem_addr[15:8] ^ 8'h7C; expected bytes are hand-computed.
module tb_cart_sdram_arb;
    import cart_pkg::*;

    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          ld_ack;
    logic          ld_wait;
    logic          a_req;
    logic [AW-1:0] a_addr;
    logic          a_ack;
    logic [7:0]    a_dout;
    logic          b_req;
    logic [AW-1:0] b_addr;
    logic          b_ack;
    logic [7:0]    b_dout;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we;
    logic          mem_rd;
    logic [7:0]    mem_dout;
    logic          mem_ready;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    // Command log filled by the monitor
    int            cmd_n  = 0;
    int            rd_hi  = 0;
    bit            cmd_we   [0:63];
    logic [AW-1:0] cmd_addr [0:63];
    logic [7:0]    cmd_din  [0:63];

    cart_sdram_arb #(.AW(AW), .TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ack    (ld_ack),
        .ld_wait   (ld_wait),
        .a_req     (a_req),
        .a_addr    (a_addr),
        .a_ack     (a_ack),
        .a_dout    (a_dout),
        .b_req     (b_req),
        .b_addr    (b_addr),
        .b_ack     (b_ack),
        .b_dout    (b_dout),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd),
        .mem_dout  (mem_dout),
        .mem_ready (mem_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    assign mem_dout = mem_addr[7:0] ^ mem_addr[15:8] ^ 8'h7C;

    // Log every SDRAM command (values of the cycle just ended)
    always @(posedge clk) begin
        if (mem_rd) rd_hi <= rd_hi + 1;
        if ((mem_rd || mem_we) && cmd_n < 64) begin
            cmd_we[cmd_n]   <= mem_we;
            cmd_addr[cmd_n] <= mem_addr;
            cmd_din[cmd_n]  <= mem_din;
            cmd_n           <= cmd_n + 1;
        end
    end

    task automatic do_reset();
        reset     = 1'b1;
        ld_req    = 1'b0; ld_addr = '0; ld_data = 8'h00;
        a_req     = 1'b0; a_addr  = '0;
        b_req     = 1'b0; b_addr  = '0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_ack(input int port, output int lat);
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if ((port == 0 && ld_ack) || (port == 1 && a_ack) || (port == 2 && b_ack)) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({ld_ack, a_ack, b_ack, mem_we, mem_rd, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000", {ld_ack, a_ack, b_ack, mem_we, mem_rd, err});
        end
        n_checks++;
        if (a_dout !== 8'hFF || b_dout !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_dout: got a=%h b=%h expected FF FF", a_dout, b_dout);
        end
        n_checks++;
        if (mem_addr !== 25'h0 || mem_din !== 8'h00 || ld_wait !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mem: got addr=%h din=%h ld_wait=%b expected 0 0 0", mem_addr, mem_din, ld_wait);
        end
    endtask

    task automatic test_priority();
        int order [0:2];
        int n_ack = 0;
        int base;
        do_reset();
        base = cmd_n;
        ld_addr = 25'h000123; ld_data = 8'h5A; ld_req = 1'b1;
        a_addr  = 25'h000200; a_req = 1'b1;
        b_addr  = 25'h000300; b_req = 1'b1;
        #1;
        n_checks++;
        if (ld_wait !== 1'b1) begin
            n_fail++;
            $display("FAIL ld_wait_pending: got %b expected 1", ld_wait);
        end
        for (int i = 0; i < 100 && n_ack < 3; i++) begin
            @(negedge clk);
            if (ld_ack) begin
                n_checks++;
                if (ld_wait !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ld_wait_on_ack: got %b expected 0", ld_wait);
                end
                order[n_ack] = 0; n_ack++; ld_req = 1'b0;
            end
            if (a_ack) begin
                n_checks++;
                if (a_dout !== 8'h7E) begin
                    n_fail++;
                    $display("FAIL prio_a_data: got %h expected 7E", a_dout);
                end
                if (n_ack < 3) order[n_ack] = 1;
                n_ack++; a_req = 1'b0;
            end
            if (b_ack) begin
                n_checks++;
                if (b_dout !== 8'h7F) begin
                    n_fail++;
                    $display("FAIL prio_b_data: got %h expected 7F", b_dout);
                end
                if (n_ack < 3) order[n_ack] = 2;
                n_ack++; b_req = 1'b0;
            end
        end
        n_checks++;
        if (n_ack != 3 || order[0] != 0 || order[1] != 1 || order[2] != 2) begin
            n_fail++;
            $display("FAIL prio_order: got %0d acks order %0d,%0d,%0d expected 3 acks order 0,1,2",
                     n_ack, order[0], order[1], order[2]);
        end
        @(negedge clk);
        n_checks++;
        if (cmd_n - base != 3 || cmd_we[base] !== 1'b1 || cmd_addr[base] !== 25'h000123 || cmd_din[base] !== 8'h5A) begin
            n_fail++;
            $display("FAIL prio_write_cmd: got n=%0d we=%b addr=%h din=%h expected 3 1 000123 5A",
                     cmd_n - base, cmd_we[base], cmd_addr[base], cmd_din[base]);
        end
        n_checks++;
        if (cmd_we[base+1] !== 1'b0 || cmd_addr[base+1] !== 25'h000200 ||
            cmd_we[base+2] !== 1'b0 || cmd_addr[base+2] !== 25'h000300) begin
            n_fail++;
            $display("FAIL prio_read_cmds: got %h %h expected 000200 000300", cmd_addr[base+1], cmd_addr[base+2]);
        end
    endtask

    task automatic test_round_robin();
        int base;
        int n_ack = 0;
        do_reset();
        base = cmd_n;
        a_addr = 25'h010000; a_req = 1'b1;
        b_addr = 25'h020000; b_req = 1'b1;
        for (int i = 0; i < 100 && n_ack < 4; i++) begin
            @(negedge clk);
            if (a_ack) begin a_addr = a_addr + 25'd1; n_ack++; end
            if (b_ack) begin b_addr = b_addr + 25'd1; n_ack++; end
        end
        a_req = 1'b0; b_req = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (n_ack != 4 || cmd_n - base < 4) begin
            n_fail++;
            $display("FAIL rr_progress: got %0d acks %0d cmds expected 4 and >=4", n_ack, cmd_n - base);
        end
        n_checks++;
        if (cmd_addr[base] !== 25'h010000 || cmd_addr[base+1] !== 25'h020000 ||
            cmd_addr[base+2] !== 25'h010001 || cmd_addr[base+3] !== 25'h020001) begin
            n_fail++;
            $display("FAIL rr_sequence: got %h %h %h %h expected 010000 020000 010001 020001",
                     cmd_addr[base], cmd_addr[base+1], cmd_addr[base+2], cmd_addr[base+3]);
        end
    endtask

    task automatic test_cache_hit();
        int lat;
        int rd0;
        do_reset();
        a_addr = 25'h004000; a_req = 1'b1;
        wait_ack(1, lat);
        a_req = 1'b0;
        n_checks++;
        if (lat != 4 || a_dout !== 8'h3C) begin
            n_fail++;
            $display("FAIL cache_first_miss: got lat=%0d data=%h expected 4 3C", lat, a_dout);
        end
        @(negedge clk);
        rd0 = rd_hi;
        a_req = 1'b1;
        wait_ack(1, lat);
        a_req = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (lat != 1 || a_dout !== 8'h3C || rd_hi != rd0) begin
            n_fail++;
            $display("FAIL cache_hit: got lat=%0d data=%h rd=%0d expected 1 3C 0", lat, a_dout, rd_hi - rd0);
        end
        ld_addr = 25'h000050; ld_data = 8'h11; ld_req = 1'b1;
        wait_ack(0, lat);
        ld_req = 1'b0;
        n_checks++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL cache_ld_write: got lat=%0d expected 4", lat);
        end
        @(negedge clk);
        rd0 = rd_hi;
        a_req = 1'b1;
        wait_ack(1, lat);
        a_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (lat != 4 || a_dout !== 8'h3C || rd_hi != rd0 + 1) begin
            n_fail++;
            $display("FAIL cache_after_write: got lat=%0d data=%h rd=%0d expected 4 3C 1", lat, a_dout, rd_hi - rd0);
        end
    endtask

    task automatic test_slow_ready();
        int lat = 0;
        int rd0;
        do_reset();
        rd0 = rd_hi;
        a_addr = 25'h000777; a_req = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) begin
                n_checks++;
                if (mem_rd !== 1'b1) begin
                    n_fail++;
                    $display("FAIL slow_cmd_cycle: got mem_rd=%b expected 1", mem_rd);
                end
                mem_ready = 1'b0;
            end
            if (i == 7) mem_ready = 1'b1;
            if (a_ack) begin lat = i; break; end
        end
        a_req = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (lat != 9 || a_dout !== 8'h0C) begin
            n_fail++;
            $display("FAIL slow_latency: got lat=%0d data=%h expected 9 0C", lat, a_dout);
        end
        n_checks++;
        if (rd_hi != rd0 + 1) begin
            n_fail++;
            $display("FAIL slow_rd_width: got %0d cycles expected 1", rd_hi - rd0);
        end
    endtask

    task automatic test_watchdog();
        int lat = 0;
        int rd0;
        do_reset();
        a_addr = 25'h000ABC; a_req = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) mem_ready = 1'b0;
            if (a_ack) begin lat = i; break; end
        end
        a_req = 1'b0;
        mem_ready = 1'b1;
        n_checks++;
        if (lat == 0 || a_dout !== 8'hFF || err !== 1'b1) begin
            n_fail++;
            $display("FAIL wdog_abort: got lat=%0d data=%h err=%b expected ack FF 1", lat, a_dout, err);
        end
        @(negedge clk);
        rd0 = rd_hi;
        a_req = 1'b1;
        wait_ack(1, lat);
        a_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (lat != 4 || rd_hi != rd0 + 1 || a_dout !== 8'hCA || err !== 1'b1) begin
            n_fail++;
            $display("FAIL wdog_not_cached: got lat=%0d rd=%0d data=%h err=%b expected 4 1 CA 1",
                     lat, rd_hi - rd0, a_dout, err);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int n_ack = 0;
        // err is still set from the watchdog scenario
        a_addr = 25'h000555; a_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) mem_ready = 1'b0;
        end
        n_checks++;
        if (dut.state_r !== WAIT || err !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: got state=%0d err=%b expected %0d 1", dut.state_r, err, WAIT);
        end
        reset = 1'b1; a_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dut.state_r !== IDLE || a_ack !== 1'b0 || a_dout !== 8'hFF || err !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_state: got state=%0d ack=%b dout=%h err=%b expected %0d 0 FF 0",
                     dut.state_r, a_ack, a_dout, err, IDLE);
        end
        reset = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (a_ack) n_ack++;
        end
        n_checks++;
        if (n_ack != 0) begin
            n_fail++;
            $display("FAIL midrst_no_ack: got %0d acks expected 0", n_ack);
        end
        a_req = 1'b1;
        wait_ack(1, lat);
        a_req = 1'b0;
        n_checks++;
        if (lat != 4 || a_dout !== 8'h2C) begin
            n_fail++;
            $display("FAIL midrst_fresh: got lat=%0d data=%h expected 4 2C", lat, a_dout);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_round_robin();
        test_cache_hit();
        test_slow_ready();
        test_watchdog();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cart_sdram_arb.md
# cart_sdram_arb

Sequencer and arbiter for the cartridge SDRAM port. It shares a single byte-wide SDRAM controller command interface between three requesters: the ioctl ROM loader (writes), cartridge slot A reads and cartridge slot B reads. It sits between the mapper address logic of the two cart instances and the SDRAM controller, replacing direct `we`/`rd` wiring. It also provides a one-entry read cache per slot, a loader back-pressure signal and a stuck-controller watchdog.

## Interface
Parameters:
- AW, 25, byte address width of SDRAM and of all request addresses
- TIMEOUT, 1023, cycles in WAIT before the watchdog aborts; must be ≥ 2

Ports:
- clk  in  1  system clock; all logic is on this edge
- reset  in  1  synchronous, active-high
- ld_req  in  1  loader write request; level, held until ld_ack
- ld_addr  in  AW  loader byte address
- ld_data  in  8  loader byte
- ld_ack  out  1  one-cycle pulse: write completed
- ld_wait  out  1  high while ld_req is pending and not yet acked (drives ioctl_wait)
- a_req / b_req  in  1  slot read request; level, held until ack
- a_addr / b_addr  in  AW  mapped read address
- a_ack / b_ack  out  1  one-cycle pulse: data valid
- a_dout / b_dout  out  8  read data; held stable until the next ack on that port
- mem_addr  out  AW  address to the SDRAM controller
- mem_din  out  8  write data to the SDRAM controller
- mem_we  out  1  one-cycle write command
- mem_rd  out  1  one-cycle read command
- mem_dout  in  8  read data from the controller
- mem_ready  in  1  controller idle / previous command complete
- err  out  1  sticky watchdog flag; cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, mem_ready=1: grant priority is loader > slot port. A and B alternate round-robin via the `last` bit: the port not served last wins a tie. `last` resets to B, so A wins the first tie.
- Cache hit: a read request whose address equals that port's valid cached address acks from the cache in IDLE. No SDRAM command is issued and `last` is unchanged.
- Cache miss: the grantee is latched in `gnt` with its address and data. The arbiter pulses mem_we or mem_rd for exactly one cycle with mem_addr/mem_din, then goes to ISSUE.
- ISSUE: lasts one cycle and ignores mem_ready, so a stale ready is not consumed. Then go to WAIT.
- WAIT: on mem_ready=1, capture mem_dout for reads and go to DONE.
- DONE: pulse the grantee's ack, update its cache (reads only), toggle `last` for slot grants, then return to IDLE.
- Every loader write clears both cache-valid bits, because ROM contents have changed.
- Watchdog: a counter runs in WAIT. When it reaches TIMEOUT, set err and complete the request. Reads complete with data 0xFF, which is not cached; writes complete normally so the loader is not stuck.
- A request dropped before its ack is a protocol violation. Behaviour is undefined, but the FSM must still return to IDLE.

## Timing
- Reset values: all acks=0, mem_we=mem_rd=0, mem_addr=0, mem_din=0, a_dout=b_dout=0xFF, err=0, caches invalid, state IDLE, `last`=B, watchdog=0.
- Cache-hit latency: request seen in IDLE at cycle n, ack at n+1.
- Miss latency: command at n+1, ISSUE at n+2, earliest WAIT exit at n+3, ack at n+4 if mem_ready is already high. Each extra not-ready cycle adds one.
- The requester must sample ack. A request still high on the cycle after its ack is treated as a new request.
- ld_wait is combinational: ld_req & ~ld_ack.
- Reset asserted mid-transaction: abort immediately to reset values. No ack is produced.

## Structure
- Shared package `cart_pkg`: state enum (IDLE/ISSUE/WAIT/DONE), grant encoding (GNT_LD=0, GNT_A=1, GNT_B=2), and constant RD_ABORT=8'hFF.
- One natural sub-module, `cart_rd_cache`. It is a one-entry address/data/valid register with a hit compare, a fill and a clear, and is instantiated twice.
- The FSM, arbiter and watchdog stay in the top level.

## Test plan
- Simultaneous ld_req (0x000123, 0x5A), a_req and b_req in IDLE: loader is granted first (mem_we with addr 0x000123, data 0x5A). Then A, then B, each read acked with its mem_dout value.
- A and B each request continuously with distinct addresses; mem_ready is stuck high: grants alternate A,B,A,B, and the first grant after reset is A.
- Read A at 0x004000 returning 0x3C, then repeat the same address: second ack arrives 1 cycle after the request, with no mem_rd pulse and a_dout=0x3C. A loader write in between forces a miss.
- mem_ready held low for 5 cycles after the command: ack arrives at cycle n+9, and mem_rd is high for exactly one cycle.
- mem_ready held low forever with TIMEOUT=16: a_ack fires with a_dout=0xFF and err=1 stays set. The next read of the same address issues mem_rd (not cached).
- Reset asserted during WAIT: the next cycle shows state IDLE, no ack, a_dout=0xFF and err=0. A fresh request afterwards completes normally.
